// File: rtl/mips_reg_file.sv
// -----------------------------------------------------------------------------
// mips_reg_file
// 32-entry general-purpose register file for the single-cycle MIPS datapath.
// Two combinational read ports (rs/rt), one synchronous write port, a debug
// read port and a committed-write counter. Register $0 reads as zero, $sp
// loads a programmable value on reset, and an optional write-through bypass
// forwards the writeback value to the read ports in the same cycle.
//
// Ports:
//   clk          system clock, all state updates on rising edge
//   reset        synchronous active-high reset
//   read_reg1    read port 1 index (rs)
//   read_reg2    read port 2 index (rt)
//   write_reg    write index
//   write_data   writeback value
//   reg_write    write enable
//   read_data1   port 1 data (ALU a)
//   read_data2   port 2 data (ALU b mux / store data)
//   dbg_addr     debug read index
//   dbg_data     debug read data, never bypassed
//   write_count  number of committed writes (16-bit, wraps)
// -----------------------------------------------------------------------------
module mips_reg_file #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0]  SP_RESET   = DATA_WIDTH'(32'h0000_03FC),
  parameter bit                     BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [15:0]           write_count
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned SP_INDEX  = 29;
  localparam int unsigned CNT_WIDTH = 16;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  wr_en_c;

  // A write commits only outside reset and never to $0.
  assign wr_en_c = ~reset & reg_write & (write_reg != '0);

  // Committed-write counter next state; wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if (wr_en_c) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // Register storage: reset image clears all but $sp.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
      end
    end else if (wr_en_c) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign write_count = count_q;

  // Read port 1: stored value, optional write-first forward, then $0/reset masking.
  always_comb begin
    read_data1 = regs_q[read_reg1];
    if (BYPASS && wr_en_c && (read_reg1 == write_reg)) begin
      read_data1 = write_data;
    end
    if (reset || (read_reg1 == '0)) begin
      read_data1 = '0;
    end
  end

  // Read port 2: evaluated independently of port 1.
  always_comb begin
    read_data2 = regs_q[read_reg2];
    if (BYPASS && wr_en_c && (read_reg2 == write_reg)) begin
      read_data2 = write_data;
    end
    if (reset || (read_reg2 == '0)) begin
      read_data2 = '0;
    end
  end

  // Debug port shows committed state only.
  always_comb begin
    dbg_data = regs_q[dbg_addr];
    if (reset || (dbg_addr == '0)) begin
      dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_mips_reg_file.sv
module tb_mips_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  read_reg1 = '0, read_reg2 = '0, write_reg = '0, dbg_addr = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0;

  logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
  logic [15:0] wc_b, wc_n;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mem [32];
  logic [15:0] m_cnt;
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  mips_reg_file #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_b), .read_data2(rd2_b), .dbg_addr(dbg_addr),
    .dbg_data(dbg_b), .write_count(wc_b)
  );

  mips_reg_file #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(rd1_n), .read_data2(rd2_n), .dbg_addr(dbg_addr),
    .dbg_data(dbg_n), .write_count(wc_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit fwd, input bit dbg);
    if (reset) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (!dbg && fwd && reg_write && write_reg != 5'd0 && a == write_reg) return write_data;
    return mem[a];
  endfunction

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("rd1_byp", rd1_b, exp_read(read_reg1, 1'b1, 1'b0));
    chk("rd2_byp", rd2_b, exp_read(read_reg2, 1'b1, 1'b0));
    chk("dbg_byp", dbg_b, exp_read(dbg_addr, 1'b1, 1'b1));
    chk("rd1_nob", rd1_n, exp_read(read_reg1, 1'b0, 1'b0));
    chk("rd2_nob", rd2_n, exp_read(read_reg2, 1'b0, 1'b0));
    chk("dbg_nob", dbg_n, exp_read(dbg_addr, 1'b0, 1'b1));
    if (model_valid) begin
      chk("wc_byp", 32'(wc_b), 32'(m_cnt));
      chk("wc_nob", 32'(wc_n), 32'(m_cnt));
    end
  endtask

  // Drive inputs mid-cycle and check combinational outputs.
  task automatic drive(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] da);
    @(negedge clk);
    reset = rst; reg_write = we; write_reg = wa; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; dbg_addr = da;
    #1;
    compare_all();
  endtask

  // Clock edge: advance the model with the inputs presented this cycle.
  task automatic commit();
    @(posedge clk);
    if (reset) begin
      foreach (mem[i]) mem[i] = 32'h0;
      mem[29] = 32'h0000_03FC;
      m_cnt = 16'h0;
    end else if (reg_write && write_reg != 5'd0) begin
      mem[write_reg] = write_data;
      m_cnt = m_cnt + 16'd1;
    end
    model_valid = 1'b1;
  endtask

  initial begin
    logic [4:0]  a, r1, r2;
    logic [31:0] d;
    int          n;

    foreach (mem[i]) mem[i] = 32'h0;
    m_cnt = 16'h0;

    // Reset image
    drive(1, 0, 0, 0, 0, 0, 0);
    commit();
    drive(0, 0, 0, 0, 5'd29, 5'd5, 5'd29);
    chk("lit_sp", rd1_b, 32'h0000_03FC);
    chk("lit_r5", rd2_b, 32'h0);
    chk("lit_wc0", 32'(wc_b), 32'h0);
    chk("lit_dbg_sp", dbg_n, 32'h0000_03FC);
    commit();

    // Consecutive writes
    drive(0, 1, 5'd8, 32'hDEAD_BEEF, 0, 0, 0);
    commit();
    drive(0, 1, 5'd9, 32'h0000_0010, 0, 0, 0);
    commit();
    drive(0, 0, 0, 0, 5'd8, 5'd9, 5'd8);
    chk("lit_r8", rd1_n, 32'hDEAD_BEEF);
    chk("lit_r9", rd2_n, 32'h0000_0010);
    chk("lit_wc2", 32'(wc_n), 32'd2);
    chk("lit_dbg_r8", dbg_b, 32'hDEAD_BEEF);
    commit();

    // Write to $0 is a no-op
    drive(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    chk("lit_r0_same", rd1_b, 32'h0);
    commit();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("lit_r0_next", rd1_b, 32'h0);
    chk("lit_wc_r0", 32'(wc_b), 32'd2);
    commit();

    // Bypass versus no bypass
    drive(0, 1, 5'd12, 32'd7, 5'd12, 5'd12, 5'd12);
    chk("lit_byp1", rd1_b, 32'd7);
    chk("lit_byp2", rd2_b, 32'd7);
    chk("lit_nob1_old", rd1_n, 32'd0);
    chk("lit_nob2_old", rd2_n, 32'd0);
    chk("lit_dbg_nobyp", dbg_b, 32'd0);
    commit();
    drive(0, 0, 0, 0, 5'd12, 5'd12, 5'd12);
    chk("lit_nob1_new", rd1_n, 32'd7);
    commit();

    // Reset discards a concurrent write
    drive(0, 1, 5'd4, 32'd5, 0, 0, 0);
    commit();
    drive(1, 1, 5'd4, 32'd9, 5'd4, 5'd4, 5'd4);
    chk("lit_rst_force", rd1_b, 32'h0);
    commit();
    drive(0, 0, 0, 0, 5'd4, 5'd29, 5'd4);
    chk("lit_r4_cleared", rd1_b, 32'h0);
    chk("lit_sp_reload", rd2_n, 32'h0000_03FC);
    chk("lit_wc_rst", 32'(wc_b), 32'h0);
    commit();

    // Randomized traffic, reads biased toward the write target
    for (int i = 0; i < 600; i++) begin
      a  = 5'($urandom_range(0, 31));
      d  = $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a, d, r1, r2,
            5'($urandom_range(0, 31)));
      commit();
    end

    // Drive the counter to its wrap point
    n = 32'(16'hFFFF - m_cnt);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      commit();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_wc_max", 32'(wc_b), 32'h0000_FFFF);
    commit();
    drive(0, 1, 5'd17, 32'hCAFE_F00D, 0, 0, 5'd17);
    commit();
    drive(0, 0, 0, 0, 5'd17, 0, 5'd17);
    chk("lit_wc_wrap", 32'(wc_b), 32'h0);
    chk("lit_wc_wrap_n", 32'(wc_n), 32'h0);
    chk("lit_dbg_last", dbg_b, 32'hCAFE_F00D);
    commit();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
